// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_BYTES    = 2;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    // States in which the loader takes a byte from the stream
    function automatic logic accepts_bytes(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects bytes LSB-first into a 32-bit little-endian word.
// 'word' already contains the byte being offered this cycle, so the
// caller can capture a complete word on the same edge that accepts
// its last byte.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [31:0]           word_q;

    // Merge the offered byte into its lane of the partial word
    always_comb begin
        // NOTE: full default before the lane insert keeps this purely combinational (no latch).
        word = word_q;
        word[{byte_idx, 3'b000} +: 8] = byte_in;
    end

    assign word_full = byte_en && (byte_idx == LAST_IDX);

    // Byte index and partial-word storage; a full word restarts at lane 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            byte_idx <= '0;
            word_q   <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (byte_en) begin
            if (byte_idx == LAST_IDX) begin
                byte_idx <= '0;
                word_q   <= '0;
            end else begin
                byte_idx <= byte_idx + 1'b1;
                word_q   <= word;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a counted byte stream, writes the
// payload words into instruction memory and releases the CPU only after
// the trailing XOR checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  restart,
    output logic                  ins_write_en,
    output logic [ADDR_WIDTH-1:0] ins_write_addr,
    output logic [DATA_WIDTH-1:0] ins_write_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // Largest word count that fits in instruction memory
    localparam logic [31:0] CAPACITY = 32'(1) << (ADDR_WIDTH - 2);

    state_t      state;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [15:0] idx_next;
    logic [15:0] hdr_count;
    logic [7:0]  xor_acc;
    logic        accept;
    logic        asm_clear;
    logic [31:0] asm_word;
    logic        asm_full;

    // rx_ready decodes the state register; forced low while reset is held
    assign rx_ready  = reset & accepts_bytes(state);
    assign accept    = rx_valid & rx_ready;
    assign asm_clear = restart & ((state == DONE) || (state == ERROR));
    assign hdr_count = {rx_data, count[7:0]};
    assign idx_next  = word_idx + 16'd1;

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (rx_data),
        .byte_en   (accept && (state == DATA)),
        .clear     (asm_clear),
        .word      (asm_word),
        .word_full (asm_full)
    );

    // Loader FSM with registered write port and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= HDR_LO;
            count          <= '0;
            word_idx       <= '0;
            xor_acc        <= '0;
            ins_write_en   <= 1'b0;
            ins_write_addr <= '0;
            ins_write_data <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            ins_write_en <= 1'b0;
            case (state)
                HDR_LO: begin
                    if (accept) begin
                        count[7:0] <= rx_data;
                        xor_acc    <= xor_acc ^ rx_data;
                        state      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        count[15:8] <= rx_data;
                        xor_acc     <= xor_acc ^ rx_data;
                        // Overflow is rejected before any payload byte is taken
                        if (32'(hdr_count) > CAPACITY) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else if (hdr_count == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        xor_acc <= xor_acc ^ rx_data;
                        if (asm_full) begin
                            state          <= WRITE;
                            ins_write_en   <= 1'b1;
                            ins_write_addr <= ADDR_WIDTH'({word_idx, 2'b00});
                            ins_write_data <= DATA_WIDTH'(asm_word);
                        end
                    end
                end
                WRITE: begin
                    word_idx <= idx_next;
                    state    <= (idx_next == count) ? CSUM : DATA;
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == xor_acc) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (restart) begin
                        state    <= HDR_LO;
                        count    <= '0;
                        word_idx <= '0;
                        xor_acc  <= '0;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                default: state <= HDR_LO;
            endcase
        end
    end

endmodule
